// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO and one-at-a-time issue engine in front of i2c_controller.
// Optional watchdog abort is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [6:0]               cmd_addr,
    input  logic [7:0]               cmd_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_rw,
    output logic [6:0]               rsp_addr,
    output logic [7:0]               rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic [6:0]               ctrl_addr,
    output logic [7:0]               ctrl_data_in,
    output logic                     ctrl_rw,
    output logic                     ctrl_enable,
    input  logic                     ctrl_ready,
    input  logic [7:0]               ctrl_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t          state, next_state;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            full, empty, push, pop, timeout;

    assign full      = (count == FULL_LEVEL);
    assign empty     = (count == '0);
    assign push      = cmd_valid & ~full;
    assign pop       = (state == IDLE) & ~empty & ctrl_ready;
    assign cmd_ready = ~full;
    assign level     = count;
    assign busy      = ~empty | (state != IDLE);

    // NOTE: the storage array has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {cmd_rw, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;
    logic          active;

    assign active  = (state == ISSUE) | (state == BUSY);
    assign timeout = active & (to_cnt == TO_LAST);
    assign rsp_err = err_q;

    // Saturating watchdog; restarted by every pop (i.e. on entry to ISSUE).
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (pop) begin
                to_cnt <= '0;
            end else if (active && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end else if (state == BUSY && ctrl_ready) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = ISSUE;
            ISSUE:   if (timeout || !ctrl_ready) next_state = (timeout ? DONE : BUSY);
            BUSY:    if (timeout || ctrl_ready) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign ctrl_enable = (state == ISSUE);
    assign rsp_valid   = (state == DONE);
    assign rsp_rw      = ctrl_rw;
    assign rsp_addr    = ctrl_addr;

    // Issue registers load only on a pop, so the controller sees stable inputs throughout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_rw      <= 1'b0;
            ctrl_addr    <= '0;
            ctrl_data_in <= '0;
            rsp_data     <= '0;
        end else begin
            if (pop) begin
                {ctrl_rw, ctrl_addr, ctrl_data_in} <= mem[rptr];
            end
            if (timeout) begin
                rsp_data <= 8'hFF;
            end else if (state == BUSY && ctrl_ready) begin
                rsp_data <= ctrl_rw ? ctrl_data_out : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: transaction-level queue model checked every
// cycle, plus literal expectations for latency, reset and boundary cases.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]             cmd_addr;
    logic [7:0]             cmd_wdata;
    logic                   rsp_valid, rsp_rw, rsp_err;
    logic [6:0]             rsp_addr;
    logic [7:0]             rsp_data;
    logic [$clog2(DEPTH):0] level;
    logic                   busy;
    logic [6:0]             ctrl_addr;
    logic [7:0]             ctrl_data_in;
    logic                   ctrl_rw, ctrl_enable, ctrl_ready;
    logic [7:0]             ctrl_data_out;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .level(level), .busy(busy),
        .ctrl_addr(ctrl_addr), .ctrl_data_in(ctrl_data_in), .ctrl_rw(ctrl_rw),
        .ctrl_enable(ctrl_enable), .ctrl_ready(ctrl_ready), .ctrl_data_out(ctrl_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: commands accepted but not yet issued, plus the one in flight.
    cmd_t       mq[$];
    cmd_t       issued, pend_cmd, head;
    bit         pend_push = 0, pend_rst = 0, inflight = 0, model_on = 0, prev_en = 0;
    bit         expect_err = 0;
    int         rsp_count = 0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] exp_data;

    always @(negedge clk) begin
        if (pend_rst) begin
            mq.delete();
            inflight  = 0;
            pend_push = 0;
            prev_en   = 0;
            model_on  = 1;
        end
        if (model_on) begin
            if (ctrl_enable && !prev_en) begin
                check("issue_from_nonempty", 32'(mq.size() != 0), 1);
                if (mq.size() != 0) begin
                    head     = mq.pop_front();
                    issued   = head;
                    inflight = 1;
                end
            end
            if (pend_push) mq.push_back(pend_cmd);
            pend_push = 0;
            check("level", 32'(level), mq.size());
            check("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
            check("busy", 32'(busy), 32'(mq.size() != 0 || inflight));
            if (inflight) begin
                check("ctrl_addr_stable", 32'(ctrl_addr), 32'(issued.addr));
                check("ctrl_data_in_stable", 32'(ctrl_data_in), 32'(issued.wdata));
                check("ctrl_rw_stable", 32'(ctrl_rw), 32'(issued.rw));
            end else begin
                check("enable_without_txn", 32'(ctrl_enable), 0);
            end
            if (rsp_valid) begin
                check("rsp_for_inflight", 32'(inflight), 1);
                exp_data = expect_err ? 8'hFF : (issued.rw ? slave_byte : 8'h00);
                check("rsp_rw", 32'(rsp_rw), 32'(issued.rw));
                check("rsp_addr", 32'(rsp_addr), 32'(issued.addr));
                check("rsp_data", 32'(rsp_data), 32'(exp_data));
                check("rsp_err", 32'(rsp_err), 32'(expect_err));
                rsp_count++;
                inflight = 0;
            end
            prev_en = ctrl_enable;
            if (cmd_valid && mq.size() < DEPTH) begin
                pend_push = 1;
                pend_cmd  = {cmd_rw, cmd_addr, cmd_wdata};
            end
        end
        pend_rst = rst;
    end

    // Controller stand-in: accept the issued command, stay busy lat cycles, return byte b.
    task automatic serve(input int lat, input logic [7:0] b);
        int n = 0;
        while (ctrl_enable !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("serve_enable_seen", 32'(ctrl_enable), 1);
        ctrl_ready = 1'b0;
        tick();
        check("serve_enable_dropped", 32'(ctrl_enable), 0);
        repeat (lat) tick();
        ctrl_data_out = b;
        slave_byte    = b;
        ctrl_ready    = 1'b1;
        tick();
        check("serve_rsp_valid", 32'(rsp_valid), 1);
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        ctrl_ready = 1'b1; ctrl_data_out = 8'h00;
        repeat (3) tick();

        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_enable", 32'(ctrl_enable), 0);
        check("rst_ctrl_addr", 32'(ctrl_addr), 0);
        check("rst_ctrl_data_in", 32'(ctrl_data_in), 0);
        check("rst_ctrl_rw", 32'(ctrl_rw), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rw", 32'(rsp_rw), 0);
        check("rst_rsp_addr", 32'(rsp_addr), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        rst = 1'b0;
        tick();

        // Single write: enable one cycle after acceptance, rsp_data forced to 0.
        push(1'b0, 7'h2A, 8'hAA);
        check("wr_enable_before_pop", 32'(ctrl_enable), 0);
        check("wr_level_after_push", 32'(level), 1);
        tick();
        check("wr_enable_at_pop", 32'(ctrl_enable), 1);
        check("wr_ctrl_addr", 32'(ctrl_addr), 'h2A);
        check("wr_ctrl_data_in", 32'(ctrl_data_in), 'hAA);
        check("wr_ctrl_rw", 32'(ctrl_rw), 0);
        serve(2, 8'h55);
        check("wr_rsp_rw", 32'(rsp_rw), 0);
        check("wr_rsp_addr", 32'(rsp_addr), 'h2A);
        check("wr_rsp_data", 32'(rsp_data), 0);
        tick();
        check("wr_rsp_one_cycle", 32'(rsp_valid), 0);

        // Single read returning DC.
        push(1'b1, 7'h2A, 8'h13);
        serve(3, 8'hDC);
        check("rd_rsp_rw", 32'(rsp_rw), 1);
        check("rd_rsp_data", 32'(rsp_data), 'hDC);
        tick();

        // Fill while the controller is busy; the extra command must be refused.
        ctrl_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i == DEPTH) check("fill_ready_low_before_extra", 32'(cmd_ready), 0);
            push(i[0], 7'(16 + i), 8'(160 + i));
        end
        check("fill_level", 32'(level), DEPTH);
        check("fill_cmd_ready", 32'(cmd_ready), 0);
        tick();
        check("fill_level_hold", 32'(level), DEPTH);
        base = rsp_count;
        ctrl_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            serve(1, 8'(192 + i));
            if (i < DEPTH - 1) begin
                tick();
                check("b2b_gap_cycle1", 32'(ctrl_enable), 0);
                tick();
                check("b2b_gap_cycle2", 32'(ctrl_enable), 1);
            end
        end
        tick();
        check("fill_rsp_count", rsp_count - base, DEPTH);
        check("fill_drained_level", 32'(level), 0);

        // Push in the same cycle as a pop at level DEPTH-1.
        ctrl_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) push(1'b1, 7'(48 + i), 8'h00);
        check("simul_level_before", 32'(level), DEPTH - 1);
        ctrl_ready = 1'b1;
        push(1'b0, 7'h3F, 8'h77);
        check("simul_level_after", 32'(level), DEPTH - 1);
        check("simul_enable", 32'(ctrl_enable), 1);
        for (int i = 0; i < DEPTH; i++) serve(2, 8'(80 + i));
        tick();

        // Reset while BUSY with two more commands queued.
        push(1'b0, 7'h11, 8'h22);
        tick();
        check("rstb_enable", 32'(ctrl_enable), 1);
        ctrl_ready = 1'b0;
        tick();
        push(1'b0, 7'h12, 8'h33);
        push(1'b1, 7'h13, 8'h44);
        check("rstb_level_before", 32'(level), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstb_level", 32'(level), 0);
        check("rstb_enable_low", 32'(ctrl_enable), 0);
        check("rstb_busy", 32'(busy), 0);
        check("rstb_no_rsp", 32'(rsp_valid), 0);
        ctrl_ready = 1'b1;
        repeat (3) tick();
        check("rstb_still_idle", 32'(busy), 0);
        push(1'b1, 7'h55, 8'h00);
        serve(2, 8'h3C);
        check("rstb_next_addr", 32'(rsp_addr), 'h55);
        check("rstb_next_data", 32'(rsp_data), 'h3C);
        tick();

`ifdef I2C_SEQ_TIMEOUT_EN
        // Controller never drops ready: watchdog aborts 16 cycles after ISSUE entry.
        begin
            int n = 0;
            expect_err = 1;
            push(1'b1, 7'h21, 8'h00);
            tick();
            check("to_enable", 32'(ctrl_enable), 1);
            while (rsp_valid !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("to_latency", n, 16);
            check("to_rsp_err", 32'(rsp_err), 1);
            check("to_rsp_data", 32'(rsp_data), 'hFF);
            tick();
            expect_err = 0;
        end
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
